// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin two-requester front end for a PISO shift register.
// Accepts one WIDTH-bit word per valid/ready handshake and drives the PISO
// parallel data and load/shift control. It also tags the serial bits with the
// owning requester.
//
// Ports:
//   clk, clr_n              - clock (rising edge), async active-low reset
//   reqK_valid/data/ready   - requester K word handshake (K = 0, 1)
//   piso_d                  - word presented to PISO D
//   piso_mode               - PISO shift control: 1 = load, 0 = shift
//   tx_active               - PISO output carries a valid serial bit
//   tx_owner                - requester owning the word in flight
//   tx_last                 - current serial bit is the final bit of the word
//
// Build option: define PISO_SCHED_B2B_EN to also accept a word on the final
// SHIFT cycle, so a sustained stream costs WIDTH+1 cycles per word.
module piso_tx_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] piso_d,
    output logic             piso_mode,
    output logic             tx_active,
    output logic             tx_owner,
    output logic             tx_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          prio;
    logic          window;
    logic          xfer;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        piso_mode = 1'b0;
        tx_active = 1'b0;
        tx_last   = 1'b0;
        window    = 1'b0;
        case (state)
            IDLE: begin
                window = 1'b1;
            end
            LOAD: begin
                piso_mode = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                tx_active = 1'b1;
                tx_last   = (cnt == LAST);
`ifdef PISO_SCHED_B2B_EN
                window    = tx_last;
`endif
                if (tx_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Ready is gated by clr_n: reset forces IDLE, whose window is open,
        // but nothing may be granted while reset is held.
        req0_ready = clr_n & window & req0_valid & (~req1_valid | ~prio);
        req1_ready = clr_n & window & req1_valid & (~req0_valid | prio);
        xfer       = req0_ready | req1_ready;

        if (xfer) begin
            state_nxt = LOAD;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt      <= '0;
            prio     <= 1'b0;
            piso_d   <= '0;
            tx_owner <= 1'b0;
        end else begin
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                cnt <= cnt + CW'(1);
            end
            if (xfer) begin
                piso_d   <= req1_ready ? req1_data : req0_data;
                tx_owner <= req1_ready;
                prio     <= ~req1_ready;
            end
        end
    end

endmodule
